bitrev_deser: RTL

BITREV_DESER -- requirements
Module: bitrev_deser

---
 rtl/bitrev_pkg.sv | 27 ++
 rtl/bitrev_fifo.sv | 65 ++++++
 rtl/bitrev_deser.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bitrev_pkg.sv
// Shared types and constants for the bit-reversing deserializer.
// Defining BITREV_DESER_PARITY_EN adds the PARITY state.
package bitrev_pkg;

  localparam int BITS_PER_FRAME = 8;

  typedef logic [BITS_PER_FRAME-1:0] byte_t;

`ifdef BITREV_DESER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;
`endif

  // Bit that makes the total number of ones (data plus parity) even.
  function automatic logic even_parity(input byte_t b);
    return ^b;
  endfunction

endpackage

// File: rtl/bitrev_fifo.sv
// Synchronous completed-byte buffer; a push into a full buffer is dropped
// and reported unless a pop frees the slot on the same edge.
module bitrev_fifo
  import bitrev_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_push,
  input  byte_t i_data,
  input  logic  i_pop,
  output logic  o_valid,
  output byte_t o_data,
  output logic  o_overrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  byte_t       r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_overrun;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Occupancy flags; the extra pointer bit separates full from empty.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = i_pop & ~w_empty;
    w_push  = i_push & (~w_full | w_pop);
  end

  // Storage, pointers and overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_overrun <= i_push & w_full & ~w_pop;
    end
  end

  assign o_valid   = ~w_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
  assign o_overrun = r_overrun;

endmodule

// File: rtl/bitrev_deser.sv
// Serial-to-byte deserializer with selectable bit order and an output buffer.
// Optional even-parity beat when BITREV_DESER_PARITY_EN is defined.
module bitrev_deser
  import bitrev_pkg::*;
#(
  parameter int LSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin_valid,
  input  logic       sin_bit,
  input  logic       sin_start,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       err_overrun,
`ifdef BITREV_DESER_PARITY_EN
  output logic       err_parity,
`endif
  output logic       frame_abort
);

  state_t     r_state;
  logic [2:0] r_cnt;
  byte_t      r_shift;
  logic       r_push;
  logic       r_busy;
  logic       r_abort;
`ifdef BITREV_DESER_PARITY_EN
  logic       r_err_parity;
`endif

  logic [2:0] w_pos;
  logic [2:0] w_first_pos;
  logic       w_last;
  logic       w_pop;
  byte_t      w_fifo_data;

  // Shift-register slot for the current bit, depending on stream order.
  always_comb begin
    if (LSB_FIRST != 0) begin
      w_pos       = r_cnt;
      w_first_pos = 3'd0;
    end else begin
      w_pos       = 3'd7 - r_cnt;
      w_first_pos = 3'd7;
    end
    w_last = (r_cnt == 3'(BITS_PER_FRAME - 1));
    w_pop  = out_valid & out_ready;
  end

  // Frame FSM; the byte is handed to the buffer one edge after completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_shift <= '0;
      r_push  <= 1'b0;
      r_busy  <= 1'b0;
      r_abort <= 1'b0;
`ifdef BITREV_DESER_PARITY_EN
      r_err_parity <= 1'b0;
`endif
    end else begin
      r_push  <= 1'b0;
      r_abort <= 1'b0;
`ifdef BITREV_DESER_PARITY_EN
      r_err_parity <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (sin_valid && sin_start) begin
            r_shift              <= '0;
            r_shift[w_first_pos] <= sin_bit;
            r_cnt                <= 3'd1;
            r_state              <= ST_DATA;
            r_busy               <= 1'b1;
          end
        end
        ST_DATA: begin
          if (sin_valid) begin
            if (sin_start) begin
              r_shift              <= '0;
              r_shift[w_first_pos] <= sin_bit;
              r_cnt                <= 3'd1;
              r_abort              <= 1'b1;
            end else begin
              r_shift[w_pos] <= sin_bit;
              if (w_last) begin
                r_cnt <= 3'd0;
`ifdef BITREV_DESER_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_push  <= 1'b1;
`endif
              end else begin
                r_cnt <= r_cnt + 3'd1;
              end
            end
          end
        end
`ifdef BITREV_DESER_PARITY_EN
        ST_PARITY: begin
          if (sin_valid) begin
            if (sin_start) begin
              r_shift              <= '0;
              r_shift[w_first_pos] <= sin_bit;
              r_cnt                <= 3'd1;
              r_state              <= ST_DATA;
              r_abort              <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              if (sin_bit == even_parity(r_shift)) begin
                r_push <= 1'b1;
              end else begin
                r_err_parity <= 1'b1;
              end
            end
          end
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  bitrev_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_push   (r_push),
    .i_data   (r_shift),
    .i_pop    (w_pop),
    .o_valid  (out_valid),
    .o_data   (w_fifo_data),
    .o_overrun(err_overrun)
  );

  assign out_data    = w_fifo_data;
  assign busy        = r_busy;
  assign frame_abort = r_abort;
`ifdef BITREV_DESER_PARITY_EN
  assign err_parity  = r_err_parity;
`endif

endmodule
